// File: rtl/hub75_fb_writein.sv
// Frame-buffer write-in engine: a producer fills a double-buffered line buffer, then a committed
// row is copied into frame-buffer memory as FB_DC words per pixel, under arbiter control.
module hub75_fb_writein #(
    parameter int unsigned N_BANKS  = 2,
    parameter int unsigned N_COLS   = 64,
    parameter int unsigned BITDEPTH = 24,
    parameter int unsigned FB_AW    = 13,
    parameter int unsigned FB_DW    = 16,
    parameter int unsigned FB_DC    = 2,
    parameter int unsigned N_ROWS   = 32,
    localparam int unsigned LOG_N_BANKS = $clog2(N_BANKS),
    localparam int unsigned LOG_N_COLS  = $clog2(N_COLS),
    localparam int unsigned LOG_N_ROWS  = $clog2(N_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITDEPTH-1:0]    wr_data,
    input  logic [LOG_N_COLS-1:0]  wr_col_addr,
    input  logic [LOG_N_BANKS-1:0] wr_bank_addr,
    input  logic                   wr_en,
    input  logic                   wr_row_swap,
    input  logic [LOG_N_ROWS-1:0]  wr_row_addr,
    input  logic                   wr_row_store,
    output logic                   wr_row_rdy,
    output logic                   ctrl_req,
    input  logic                   ctrl_gnt,
    output logic                   ctrl_rel,
    output logic [FB_AW-1:0]       fb_addr,
    output logic [FB_DW-1:0]       fb_data,
    output logic                   fb_wren
);

    localparam int unsigned LOG_FB_DC = $clog2(FB_DC);
    localparam int unsigned DC_W      = (LOG_FB_DC > 0) ? LOG_FB_DC : 1;
    localparam int unsigned PIX_W     = LOG_N_COLS + LOG_N_BANKS;
    localparam int unsigned CNT_W     = PIX_W + LOG_FB_DC;
    localparam int unsigned TOTAL     = N_COLS * N_BANKS * FB_DC;
    localparam int unsigned LB_DEPTH  = 2 * N_COLS * N_BANKS;

    typedef enum logic [2:0] {StIdle, StReq, StRun, StDrain, StRel} state_t;

    logic [BITDEPTH-1:0]     r_lbuf [LB_DEPTH];
    logic [BITDEPTH-1:0]     r_rd_data;
    logic                    r_buf_sel;
    logic                    r_eng_buf;
    state_t                  r_state;
    logic [LOG_N_ROWS-1:0]   r_row;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_req;
    logic                    r_rel;
    logic                    r_rdy;
    logic                    r_wren;
    logic [FB_AW-1:0]        r_fb_addr;
    logic [DC_W-1:0]         r_dc;

    logic [PIX_W-1:0]        w_pix_idx;
    logic [PIX_W:0]          w_wr_addr;
    logic [PIX_W:0]          w_rd_addr;
    logic [FB_DC*FB_DW-1:0]  w_pix_pad;

    // The write uses buf_sel before any same-cycle swap takes effect.
    assign w_wr_addr = {r_buf_sel, wr_col_addr, wr_bank_addr};
    assign w_pix_idx = r_cnt[CNT_W-1 -: PIX_W];
    assign w_rd_addr = {r_eng_buf, w_pix_idx};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_lbuf[w_wr_addr] <= wr_data;
        end
        r_rd_data <= r_lbuf[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_sel <= 1'b0;
        end else if (wr_row_swap) begin
            r_buf_sel <= ~r_buf_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_req     <= 1'b0;
            r_rel     <= 1'b0;
            r_rdy     <= 1'b1;
            r_row     <= '0;
            r_eng_buf <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (wr_row_store) begin
                        r_row     <= wr_row_addr;
                        r_eng_buf <= ~r_buf_sel;
                        r_req     <= 1'b1;
                        r_rdy     <= 1'b0;
                        r_state   <= StReq;
                    end
                end
                StReq: begin
                    if (ctrl_gnt) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(TOTAL - 1)) begin
                        r_state <= StDrain;
                    end
                end
                // Last pipelined write is on the bus during StDrain; release follows it.
                StDrain: begin
                    r_rel   <= 1'b1;
                    r_state <= StRel;
                end
                StRel: begin
                    r_rel   <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren    <= 1'b0;
            r_fb_addr <= '0;
            r_dc      <= '0;
        end else begin
            r_wren <= (r_state == StRun);
            if (r_state == StRun) begin
                r_fb_addr <= {r_row, r_cnt};
                r_dc      <= (FB_DC > 1) ? r_cnt[DC_W-1:0] : '0;
            end
        end
    end

    always_comb begin
        w_pix_pad = '0;
        w_pix_pad[BITDEPTH-1:0] = r_rd_data;
    end

    assign fb_data    = r_wren ? w_pix_pad[r_dc*FB_DW +: FB_DW] : '0;
    assign fb_addr    = r_fb_addr;
    assign fb_wren    = r_wren;
    assign ctrl_req   = r_req;
    assign ctrl_rel   = r_rel;
    assign wr_row_rdy = r_rdy;

endmodule

// File: tb/tb_hub75_fb_writein.sv
// Bench for hub75_fb_writein: random pixel traffic checked against an array model of the two
// line-buffer halves, with expected bursts computed from row/column/bank arithmetic.
module tb_hub75_fb_writein;

    localparam int unsigned N_BANKS  = 2;
    localparam int unsigned N_COLS   = 64;
    localparam int unsigned BITDEPTH = 24;
    localparam int unsigned FB_AW    = 13;
    localparam int unsigned FB_DW    = 16;
    localparam int unsigned FB_DC    = 2;
    localparam int unsigned N_ROWS   = 32;
    localparam int unsigned NPIX     = N_COLS * N_BANKS;
    localparam int unsigned TOTAL    = NPIX * FB_DC;

    logic                clk = 1'b0;
    logic                rst;
    logic [BITDEPTH-1:0] wr_data;
    logic [5:0]          wr_col_addr;
    logic [0:0]          wr_bank_addr;
    logic                wr_en;
    logic                wr_row_swap;
    logic [4:0]          wr_row_addr;
    logic                wr_row_store;
    logic                wr_row_rdy;
    logic                ctrl_req;
    logic                ctrl_gnt;
    logic                ctrl_rel;
    logic [FB_AW-1:0]    fb_addr;
    logic [FB_DW-1:0]    fb_data;
    logic                fb_wren;

    always #5 clk = ~clk;

    hub75_fb_writein #(
        .N_BANKS (N_BANKS),
        .N_COLS  (N_COLS),
        .BITDEPTH(BITDEPTH),
        .FB_AW   (FB_AW),
        .FB_DW   (FB_DW),
        .FB_DC   (FB_DC),
        .N_ROWS  (N_ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_col_addr (wr_col_addr),
        .wr_bank_addr(wr_bank_addr),
        .wr_en       (wr_en),
        .wr_row_swap (wr_row_swap),
        .wr_row_addr (wr_row_addr),
        .wr_row_store(wr_row_store),
        .wr_row_rdy  (wr_row_rdy),
        .ctrl_req    (ctrl_req),
        .ctrl_gnt    (ctrl_gnt),
        .ctrl_rel    (ctrl_rel),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_wren     (fb_wren)
    );

    int                  n_checks = 0;
    int                  n_pass   = 0;
    logic [BITDEPTH-1:0] model_buf [2][NPIX];
    int                  model_sel;
    logic [31:0]         mon_addr[$];
    logic [31:0]         mon_data[$];
    int                  rel_cnt;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (fb_wren === 1'b1) begin
                mon_addr.push_back(32'(fb_addr));
                mon_data.push_back(32'(fb_data));
            end
            if (ctrl_rel === 1'b1) rel_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] a);
        logic [31:0] d;
        d = 32'hFFFF_FFFF;
        foreach (mon_addr[i]) if (mon_addr[i] == a) d = mon_data[i];
        return d;
    endfunction

    task automatic pix_write(input int col, input int bank, input logic [BITDEPTH-1:0] data,
                             input bit do_swap);
        wr_en        = 1'b1;
        wr_col_addr  = 6'(col);
        wr_bank_addr = 1'(bank);
        wr_data      = data;
        wr_row_swap  = do_swap;
        model_buf[model_sel][col*N_BANKS + bank] = data;
        if (do_swap) model_sel = 1 - model_sel;
        tick();
        wr_en       = 1'b0;
        wr_row_swap = 1'b0;
    endtask

    task automatic do_swap();
        wr_row_swap = 1'b1;
        model_sel   = 1 - model_sel;
        tick();
        wr_row_swap = 1'b0;
    endtask

    task automatic fill_half();
        for (int p = 0; p < int'(NPIX); p++) pix_write(p / 2, p % 2, BITDEPTH'($urandom), 1'b0);
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++)
            pix_write($urandom_range(0, 63), $urandom_range(0, 1), BITDEPTH'($urandom),
                      ($urandom_range(0, 7) == 0));
    endtask

    // action: 0 none, 1 busy store of row 3, 2 swap then write pixel 0, 3 reset
    task automatic do_row(input int row, input int gdelay, input int action, input int act_at);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        int h;
        int idx;
        h = 1 - model_sel;
        for (int p = 0; p < int'(NPIX); p++)
            for (int dc = 0; dc < int'(FB_DC); dc++) begin
                exp_addr.push_back(32'((row * NPIX + p) * FB_DC + dc));
                exp_data.push_back(32'(model_buf[h][p] >> (FB_DW * dc)) & 32'hFFFF);
            end
        mon_addr.delete();
        mon_data.delete();
        rel_cnt = 0;
        check_eq("rdy_idle", 32'(wr_row_rdy), 1);
        wr_row_store = 1'b1;
        wr_row_addr  = 5'(row);
        tick();
        wr_row_store = 1'b0;
        check_eq("req_rise", 32'(ctrl_req), 1);
        check_eq("rdy_busy", 32'(wr_row_rdy), 0);
        repeat (gdelay) tick();
        check_eq("req_hold", 32'(ctrl_req), 1);
        ctrl_gnt = 1'b1;
        tick();
        ctrl_gnt = 1'b0;
        check_eq("req_drop", 32'(ctrl_req), 0);
        check_eq("wren_lat", 32'(fb_wren), 0);
        tick();
        idx = 0;
        while (fb_wren === 1'b1 && idx < 400) begin
            if (action == 1 && idx == act_at) begin
                wr_row_store = 1'b1;
                wr_row_addr  = 5'd3;
            end
            if (action == 2 && idx == act_at) begin
                wr_row_swap = 1'b1;
                model_sel   = 1 - model_sel;
            end
            if (action == 2 && idx == act_at + 1) begin
                wr_en        = 1'b1;
                wr_col_addr  = 6'd0;
                wr_bank_addr = 1'b0;
                wr_data      = 24'h123456;
                model_buf[model_sel][0] = 24'h123456;
            end
            if (action == 3 && idx == act_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_sel = 0;
                check_eq("rst_wren", 32'(fb_wren), 0);
                check_eq("rst_req", 32'(ctrl_req), 0);
                check_eq("rst_rel", 32'(ctrl_rel), 0);
                check_eq("rst_rdy", 32'(wr_row_rdy), 1);
                return;
            end
            tick();
            wr_row_store = 1'b0;
            wr_row_swap  = 1'b0;
            wr_en        = 1'b0;
            idx++;
        end
        check_eq("wren_len", 32'(idx), TOTAL);
        check_eq("rel_pulse", 32'(ctrl_rel), 1);
        tick();
        check_eq("rel_once", 32'(ctrl_rel), 0);
        check_eq("rdy_back", 32'(wr_row_rdy), 1);
        check_eq("rel_count", 32'(rel_cnt), 1);
        check_eq("burst_words", 32'(mon_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
            check_eq("fb_addr", mon_addr[i], exp_addr[i]);
            check_eq("fb_data", mon_data[i], exp_data[i]);
        end
    endtask

    initial begin
        int r;
        rst          = 1'b1;
        wr_data      = '0;
        wr_col_addr  = '0;
        wr_bank_addr = '0;
        wr_en        = 1'b0;
        wr_row_swap  = 1'b0;
        wr_row_addr  = '0;
        wr_row_store = 1'b0;
        ctrl_gnt     = 1'b0;
        model_sel    = 0;
        rel_cnt      = 0;
        repeat (3) tick();
        check_eq("rst_req0", 32'(ctrl_req), 0);
        check_eq("rst_rel0", 32'(ctrl_rel), 0);
        check_eq("rst_wren0", 32'(fb_wren), 0);
        check_eq("rst_addr0", 32'(fb_addr), 0);
        check_eq("rst_data0", 32'(fb_data), 0);
        check_eq("rst_rdy0", 32'(wr_row_rdy), 1);
        rst = 1'b0;
        tick();

        fill_half();
        do_swap();
        fill_half();
        do_swap();

        // Grant outside REQ must not start anything.
        ctrl_gnt = 1'b1;
        tick();
        ctrl_gnt = 1'b0;
        check_eq("idle_gnt_req", 32'(ctrl_req), 0);
        check_eq("idle_gnt_wren", 32'(fb_wren), 0);
        check_eq("idle_gnt_rdy", 32'(wr_row_rdy), 1);

        // Single pixel path.
        pix_write(5, 1, 24'hABCDEF, 1'b0);
        do_swap();
        do_row(7, 0, 0, 0);
        check_eq("s1_lo", lookup(32'h716), 32'hCDEF);
        check_eq("s1_hi", lookup(32'h717), 32'h00AB);

        // Handshake with a late grant.
        rand_writes(40);
        do_swap();
        do_row($urandom_range(0, 31), 3, 0, 0);

        // Store during RUN is ignored.
        rand_writes(30);
        do_swap();
        do_row(9, 1, 1, 10);
        tick();
        check_eq("busy_noreq1", 32'(ctrl_req), 0);
        tick();
        check_eq("busy_noreq2", 32'(ctrl_req), 0);

        // Swap and write into the new producer half during RUN.
        rand_writes(30);
        do_swap();
        do_row($urandom_range(0, 31), 2, 2, 50);
        do_swap();
        r = $urandom_range(0, 31);
        do_row(r, 0, 0, 0);
        check_eq("s4_lo", lookup(32'(r * TOTAL)), 32'h3456);
        check_eq("s4_hi", lookup(32'(r * TOTAL + 1)), 32'h0012);

        // Reset at write index 100, then a fresh store.
        do_swap();
        do_row($urandom_range(0, 31), 1, 3, 100);
        tick();
        rand_writes(20);
        do_row($urandom_range(0, 31), $urandom_range(0, 4), 0, 0);

        // Back-to-back rows.
        rand_writes(25);
        do_swap();
        do_row(1, 0, 0, 0);
        do_row(2, 1, 0, 0);

        for (int k = 0; k < 3; k++) begin
            rand_writes($urandom_range(20, 60));
            if ($urandom_range(0, 1) == 1) do_swap();
            do_row($urandom_range(0, 31), $urandom_range(0, 5), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
